// File: rtl/mipi_rx_lane_merge_if.sv
// Lane-merge port bundle: per-lane D-PHY receive bytes/flags in, merged word stream and status out.
// The master modport is the PHY/controller side; the slave modport is the merge block.
interface mipi_rx_lane_merge_if;
    logic        en;
    logic [7:0]  d0hsrxdata;
    logic        d0sync;
    logic        d0errsync;
    logic        d0nosync;
    logic [7:0]  d1hsrxdata;
    logic        d1sync;
    logic        d1errsync;
    logic        d1nosync;
    logic [15:0] outdata;
    logic        outvalid;
    logic        outsop;
    logic        outeop;
    logic        skewerr;
    logic        nosyncerr;
    logic        errsyncseen;
    logic        busy;

    modport master (
        output en, d0hsrxdata, d0sync, d0errsync, d0nosync,
               d1hsrxdata, d1sync, d1errsync, d1nosync,
        input  outdata, outvalid, outsop, outeop, skewerr, nosyncerr, errsyncseen, busy
    );

    modport slave (
        input  en, d0hsrxdata, d0sync, d0errsync, d0nosync,
               d1hsrxdata, d1sync, d1errsync, d1nosync,
        output outdata, outvalid, outsop, outeop, skewerr, nosyncerr, errsyncseen, busy
    );
endinterface

// File: rtl/mipi_rx_lane_merge.sv
// 2-lane D-PHY byte deskew and merge: per-lane FIFOs aligned on SYNC, merged into 16-bit words
// with SOP/EOP framing and sticky sync/skew error reporting.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | no burst; FIFOs, skew counter and hold register cleared
// WAIT_SYNC | EN high, collecting bytes from synced lanes, timing lane skew
// STREAM    | both lanes aligned, popping pairs, emitting the held word
// FLUSH     | EN dropped, draining pairs until the lagging lane runs dry
// ERROR     | skew/overflow/nosync fault, output muted until EN drops
module mipi_rx_lane_merge #(
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 2
) (
    input logic             clkhsbyte,
    input logic             rstn,
    mipi_rx_lane_merge_if.slave lm
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_SKEW + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_STREAM,
        S_FLUSH,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [7:0]  mem0 [DEPTH];
    logic [7:0]  mem1 [DEPTH];
    logic [AW:0] wptr0_q, rptr0_q, wptr1_q, rptr1_q;
    logic        empty0, empty1, full0, full1;
    logic [7:0]  rd0, rd1;

    logic          synced0_q, synced1_q;
    logic [SW-1:0] skewcnt_q, cur_skew;
    logic          ev0, ev1, s0, s1;

    logic [15:0] hold_q;
    logic        hold_v_q;
    logic        sop_pend_q;
    logic        skewerr_q, nosyncerr_q, errsyncseen_q;

    logic wr0, wr1, pop, ovf, emit, eop;
    logic set_skew, set_nosync, set_errs, clr_flags;

    assign empty0 = (wptr0_q == rptr0_q);
    assign empty1 = (wptr1_q == rptr1_q);
    assign full0  = (wptr0_q[AW] != rptr0_q[AW]) && (wptr0_q[AW-1:0] == rptr0_q[AW-1:0]);
    assign full1  = (wptr1_q[AW] != rptr1_q[AW]) && (wptr1_q[AW-1:0] == rptr1_q[AW-1:0]);
    assign rd0    = mem0[rptr0_q[AW-1:0]];
    assign rd1    = mem1[rptr1_q[AW-1:0]];

    // An ERRSYNC is still a usable sync; it only raises the informational flag.
    assign ev0      = lm.en & (lm.d0sync | lm.d0errsync);
    assign ev1      = lm.en & (lm.d1sync | lm.d1errsync);
    assign s0       = synced0_q | ev0;
    assign s1       = synced1_q | ev1;
    assign cur_skew = (synced0_q | synced1_q) ? skewcnt_q : '0;

    always_ff @(posedge clkhsbyte or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr0        = 1'b0;
        wr1        = 1'b0;
        pop        = 1'b0;
        ovf        = 1'b0;
        emit       = 1'b0;
        eop        = 1'b0;
        set_skew   = 1'b0;
        set_nosync = 1'b0;
        set_errs   = 1'b0;
        clr_flags  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lm.en) begin
                    state_d   = S_WAIT_SYNC;
                    clr_flags = 1'b1;
                end
            end
            S_WAIT_SYNC: begin
                if (!lm.en) begin
                    state_d = S_IDLE;
                end else begin
                    wr0      = s0;
                    wr1      = s1;
                    set_errs = lm.d0errsync | lm.d1errsync;
                    if (lm.d0nosync | lm.d1nosync) begin
                        set_nosync = 1'b1;
                        state_d    = S_ERROR;
                    end else if (s0 & s1) begin
                        state_d = S_STREAM;
                    end else if ((s0 | s1) && (cur_skew == SW'(MAX_SKEW))) begin
                        // Next cycle would be skew MAX_SKEW+1 with one lane still unsynced.
                        set_skew = 1'b1;
                        state_d  = S_ERROR;
                    end
                end
            end
            S_STREAM: begin
                pop = !empty0 && !empty1;
                ovf = lm.en && (full0 || full1) && !pop;
                if (ovf) begin
                    pop      = 1'b0;
                    set_skew = 1'b1;
                    state_d  = S_ERROR;
                end else begin
                    wr0  = lm.en;
                    wr1  = lm.en;
                    emit = pop & hold_v_q;
                    if (!lm.en) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!empty0 && !empty1) begin
                    pop  = 1'b1;
                    emit = hold_v_q;
                end else begin
                    emit    = hold_v_q;
                    eop     = hold_v_q;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (!lm.en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkhsbyte) begin
        if (wr0) begin
            mem0[wptr0_q[AW-1:0]] <= lm.d0hsrxdata;
        end
        if (wr1) begin
            mem1[wptr1_q[AW-1:0]] <= lm.d1hsrxdata;
        end
    end

    always_ff @(posedge clkhsbyte or negedge rstn) begin
        if (!rstn) begin
            wptr0_q    <= '0;
            rptr0_q    <= '0;
            wptr1_q    <= '0;
            rptr1_q    <= '0;
            synced0_q  <= 1'b0;
            synced1_q  <= 1'b0;
            skewcnt_q  <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            sop_pend_q <= 1'b1;
        end else if (state_q == S_IDLE) begin
            wptr0_q    <= '0;
            rptr0_q    <= '0;
            wptr1_q    <= '0;
            rptr1_q    <= '0;
            synced0_q  <= 1'b0;
            synced1_q  <= 1'b0;
            skewcnt_q  <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            sop_pend_q <= 1'b1;
        end else begin
            if (wr0) wptr0_q <= wptr0_q + (AW+1)'(1);
            if (wr1) wptr1_q <= wptr1_q + (AW+1)'(1);
            if (pop) begin
                rptr0_q <= rptr0_q + (AW+1)'(1);
                rptr1_q <= rptr1_q + (AW+1)'(1);
            end
            if (state_q == S_WAIT_SYNC) begin
                synced0_q <= s0;
                synced1_q <= s1;
                if (s0 | s1) begin
                    skewcnt_q <= cur_skew + SW'(1);
                end
            end
            if (state_d == S_ERROR || state_d == S_IDLE) begin
                hold_q   <= '0;
                hold_v_q <= 1'b0;
            end else if (pop) begin
                hold_q   <= {rd1, rd0};
                hold_v_q <= 1'b1;
            end
            if (emit) begin
                sop_pend_q <= 1'b0;
            end
        end
    end

    // Sticky flags survive the return to IDLE so the protocol layer can read them after ERROR.
    always_ff @(posedge clkhsbyte or negedge rstn) begin
        if (!rstn) begin
            skewerr_q     <= 1'b0;
            nosyncerr_q   <= 1'b0;
            errsyncseen_q <= 1'b0;
        end else if (clr_flags) begin
            skewerr_q     <= 1'b0;
            nosyncerr_q   <= 1'b0;
            errsyncseen_q <= 1'b0;
        end else begin
            if (set_skew)   skewerr_q     <= 1'b1;
            if (set_nosync) nosyncerr_q   <= 1'b1;
            if (set_errs)   errsyncseen_q <= 1'b1;
        end
    end

    assign lm.outdata     = hold_q;
    assign lm.outvalid    = emit;
    assign lm.outsop      = emit & sop_pend_q;
    assign lm.outeop      = eop;
    assign lm.skewerr     = skewerr_q;
    assign lm.nosyncerr   = nosyncerr_q;
    assign lm.errsyncseen = errsyncseen_q;
    assign lm.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mipi_rx_lane_merge.sv
// Bench for mipi_rx_lane_merge: bursts are described by sync cycles and EN length, and the
// expected word stream and flags are derived from those alone, cycle by cycle.
module tb_mipi_rx_lane_merge;

    localparam int DEPTH    = 4;
    localparam int MAX_SKEW = 2;

    logic clkhsbyte = 1'b0;
    logic rstn      = 1'b0;

    mipi_rx_lane_merge_if lm();

    mipi_rx_lane_merge #(.DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW)) dut (
        .clkhsbyte(clkhsbyte),
        .rstn     (rstn),
        .lm       (lm)
    );

    always #5 clkhsbyte = ~clkhsbyte;

    int checks = 0;
    int passed = 0;
    bit p_skew = 1'b0, p_nos = 1'b0, p_errs = 1'b0;
    logic [7:0] b0 [128];
    logic [7:0] b1 [128];

    task automatic drive_quiet();
        lm.en = 1'b0;
        lm.d0hsrxdata = 8'h00; lm.d0sync = 1'b0; lm.d0errsync = 1'b0; lm.d0nosync = 1'b0;
        lm.d1hsrxdata = 8'h00; lm.d1sync = 1'b0; lm.d1errsync = 1'b0; lm.d1nosync = 1'b0;
    endtask

    // s0/s1: cycle of each lane's SYNC (-1 none), e: first EN=0 cycle, rst_at: reset cycle (-1 none)
    task automatic run_burst(input string name, input int s0, input int s1, input int e,
                             input int nos_at, input bit nos_lane, input bit errs,
                             input bit noise, input int rst_at);
        int first, last, n, ts;
        bit good, skewbad, in_rst, ev, es, ee, fs, fn, fe, fb;
        logic [15:0] exp_d, obs_d;
        logic [3:0]  exp_s, obs_s;
        if (s0 >= 0 && s1 >= 0) begin
            first = (s0 < s1) ? s0 : s1;
            last  = (s0 < s1) ? s1 : s0;
        end else if (s0 >= 0) begin
            first = s0; last = s0;
        end else begin
            first = s1; last = s1;
        end
        good    = (s0 >= 0) && (s1 >= 0) && (last - first <= MAX_SKEW) && (nos_at < 0);
        skewbad = (first >= 0) && !good && (nos_at < 0);
        ts      = first + MAX_SKEW + 1;
        n       = e - last;
        fs = p_skew; fn = p_nos; fe = p_errs;
        for (int k = 0; k <= e + 4; k++) begin
            @(posedge clkhsbyte);
            #1;
            in_rst = (rst_at >= 0) && (k >= rst_at);
            if (rst_at >= 0 && k == rst_at)     rstn = 1'b0;
            if (rst_at >= 0 && k == rst_at + 3) rstn = 1'b1;
            b0[k] = 8'($urandom);
            b1[k] = 8'($urandom);
            lm.en         = (k < e) && !in_rst;
            lm.d0hsrxdata = b0[k];
            lm.d1hsrxdata = b1[k];
            lm.d0sync     = (k == s0);
            lm.d1sync     = (k == s1);
            lm.d0errsync  = 1'b0;
            lm.d1errsync  = errs && (k == s1);
            lm.d0nosync   = (k == nos_at) && !nos_lane;
            lm.d1nosync   = (k == nos_at) && nos_lane;
            if (noise && good && (k == 0 || k > last)) begin
                lm.d0sync   = 1'($urandom_range(0, 1));
                lm.d1sync   = 1'($urandom_range(0, 1));
                lm.d0nosync = 1'($urandom_range(0, 1));
                lm.d1nosync = 1'($urandom_range(0, 1));
            end
            @(negedge clkhsbyte);
            if (in_rst) begin
                ev = 0; es = 0; ee = 0; fb = 0; fs = 0; fn = 0; fe = 0;
                exp_d = 16'h0000;
            end else begin
                ev = good && (k >= last + 2) && (k <= last + 1 + n);
                es = ev && (k == last + 2);
                ee = ev && (k == last + 1 + n);
                exp_d = ev ? {b1[s1 + k - last - 2], b0[s0 + k - last - 2]} : 16'h0000;
                fb = good ? (k >= 1 && k <= last + 1 + n) : (k >= 1 && k <= e);
                if (k >= 1) begin
                    fs = skewbad && (k >= ts);
                    fn = (nos_at >= 0) && (k > nos_at);
                    fe = errs && good && (k > s1);
                end
            end
            obs_d = (ev || in_rst) ? lm.outdata : 16'h0000;
            checks++;
            if ({lm.outvalid, lm.outsop, lm.outeop, obs_d} !== {ev, es, ee, exp_d}) begin
                $display("FAIL %s word k=%0d got v=%0b sop=%0b eop=%0b d=%04h want v=%0b sop=%0b eop=%0b d=%04h",
                         name, k, lm.outvalid, lm.outsop, lm.outeop, obs_d, ev, es, ee, exp_d);
            end else begin
                passed++;
            end
            exp_s = {fs, fn, fe, fb};
            obs_s = {lm.skewerr, lm.nosyncerr, lm.errsyncseen, lm.busy};
            checks++;
            if (obs_s !== exp_s) begin
                $display("FAIL %s status k=%0d got skew/nosync/errsync/busy=%04b want %04b",
                         name, k, obs_s, exp_s);
            end else begin
                passed++;
            end
        end
        p_skew = fs; p_nos = fn; p_errs = fe;
    endtask

    task automatic test_reset();
        drive_quiet();
        rstn = 1'b0;
        repeat (2) @(negedge clkhsbyte);
        checks++;
        if ({lm.outvalid, lm.outsop, lm.outeop, lm.skewerr, lm.nosyncerr, lm.errsyncseen, lm.busy} !== 7'b0) begin
            $display("FAIL reset_flags got %07b want 0000000",
                     {lm.outvalid, lm.outsop, lm.outeop, lm.skewerr, lm.nosyncerr, lm.errsyncseen, lm.busy});
        end else begin
            passed++;
        end
        checks++;
        if (lm.outdata !== 16'h0000) begin
            $display("FAIL reset_data got %04h want 0000", lm.outdata);
        end else begin
            passed++;
        end
        @(posedge clkhsbyte);
        #1 rstn = 1'b1;
        @(negedge clkhsbyte);
        checks++;
        if ({lm.outvalid, lm.busy, lm.outdata} !== 18'h0) begin
            $display("FAIL post_reset_idle got v=%0b busy=%0b d=%04h want 0 0 0000",
                     lm.outvalid, lm.busy, lm.outdata);
        end else begin
            passed++;
        end
    endtask

    task automatic test_aligned();
        run_burst("aligned", 2, 2, 8, -1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_skew_ok();
        run_burst("skew_lane1_late", 2, 4, 10, -1, 1'b0, 1'b0, 1'b0, -1);
        run_burst("skew_lane0_late", 3, 1, 9, -1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_skew_err();
        run_burst("skew_err", 2, 5, 9, -1, 1'b0, 1'b0, 1'b0, -1);
        run_burst("skew_clear", 1, 1, 5, -1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_nosync_errsync();
        run_burst("nosync", -1, -1, 8, 3, 1'b0, 1'b0, 1'b0, -1);
        run_burst("errsync", 2, 3, 9, -1, 1'b0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_stream();
        run_burst("rst_mid", 2, 2, 12, -1, 1'b0, 1'b0, 1'b0, 7);
        run_burst("after_rst", 1, 2, 7, -1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_single_word();
        run_burst("single", 3, 3, 4, -1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        int kind, first, d, s0, s1, e, m;
        bit lead1;
        for (int b = 0; b < 25; b++) begin
            kind  = $urandom_range(0, 9);
            first = $urandom_range(1, 3);
            lead1 = 1'($urandom_range(0, 1));
            if (kind <= 5 || kind == 9) begin
                d  = $urandom_range(0, MAX_SKEW);
                s0 = lead1 ? first + d : first;
                s1 = lead1 ? first : first + d;
                e  = first + d + $urandom_range(1, 12);
                run_burst("rand_good", s0, s1, e, -1, 1'b0, kind == 9, 1'($urandom_range(0, 1)), -1);
            end else if (kind <= 7) begin
                d  = ($urandom_range(0, 3) == 0) ? -1 : MAX_SKEW + 1 + $urandom_range(0, 2);
                s0 = lead1 ? ((d < 0) ? -1 : first + d) : first;
                s1 = lead1 ? first : ((d < 0) ? -1 : first + d);
                e  = first + MAX_SKEW + 1 + $urandom_range(1, 5);
                run_burst("rand_skew", s0, s1, e, -1, 1'b0, 1'b0, 1'b0, -1);
            end else begin
                m = $urandom_range(1, 4);
                e = m + $urandom_range(1, 5);
                run_burst("rand_nosync", -1, -1, e, m, lead1, 1'b0, 1'b0, -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skew_ok();
        test_skew_err();
        test_nosync_errsync();
        test_reset_mid_stream();
        test_single_word();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
